// File: rtl/tl45_muldiv.sv
// tl45_muldiv: multi-cycle multiply/divide unit for the TL45 execute stage.
// Ports: i_clk, i_reset (sync, active-high), i_flush; request side
//   i_valid/o_ready with i_op, i_a, i_b, i_tag; result side o_valid,
//   o_result, o_tag, o_div_by_zero, held while i_stall is high.
module tl45_muldiv #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 3,
    parameter int TAG_W      = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [XLEN-1:0]  i_a,
    input  logic [XLEN-1:0]  i_b,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_stall,
    output logic             o_valid,
    output logic [XLEN-1:0]  o_result,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_div_by_zero
);

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE
    } state_t;

    localparam int CW = $clog2(XLEN + MUL_STAGES + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_STAGES - 1);
    localparam logic [CW-1:0] DIV_CNT = CW'(XLEN - 1);

    state_t state_q, state_d, first_st;

    logic accept;
    logic op_mul, op_div, op_sgn, b_zero;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
    logic [2*XLEN-1:0] pipe_q [MUL_STAGES];
    logic [2*XLEN-1:0] mul_top;
    logic [XLEN-1:0] mul_res;

    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [CW-1:0]    cnt_q;
    logic [XLEN-1:0]  a_q, dvs_q, quo_q, rem_q;
    logic             a_neg_q, b_neg_q, dz_q;

    logic [XLEN:0]    sh, dif;
    logic             ge;
    logic [XLEN-1:0]  rem_nx;

    logic [XLEN-1:0]  q_fix, r_fix, fix_res;
    logic             is_q;

    logic [XLEN-1:0]  res_q;
    logic             rdz_q;

    // Ready in DONE only when the held result is being consumed.
    assign o_ready = (state_q == S_IDLE) ||
                     (state_q == S_DONE && !i_stall);
    assign accept  = i_valid && o_ready && !i_flush;

    assign op_mul = (i_op <= 3'd2);
    assign op_div = (i_op >= 3'd3) && (i_op <= 3'd6);
    assign op_sgn = (i_op == 3'd3) || (i_op == 3'd5);
    assign b_zero = (i_b == '0);

    assign a_mag = (op_sgn && i_a[XLEN-1]) ? -i_a : i_a;
    assign b_mag = (op_sgn && i_b[XLEN-1]) ? -i_b : i_b;

    // Only MULH sign-extends; MUL low half is identical either way.
    assign mul_a = {{XLEN{(i_op == 3'd1) && i_a[XLEN-1]}}, i_a};
    assign mul_b = {{XLEN{(i_op == 3'd1) && i_b[XLEN-1]}}, i_b};
    assign mul_p = mul_a * mul_b;

    assign mul_top = pipe_q[MUL_STAGES-1];
    assign mul_res = (op_q == 3'd0) ? mul_top[XLEN-1:0]
                                    : mul_top[2*XLEN-1:XLEN];

    // Restoring step: shift next dividend bit into the partial remainder.
    assign sh     = {rem_q, quo_q[XLEN-1]};
    assign ge     = (sh >= {1'b0, dvs_q});
    assign dif    = sh - {1'b0, dvs_q};
    assign rem_nx = ge ? dif[XLEN-1:0] : sh[XLEN-1:0];

    assign is_q  = (op_q == 3'd3) || (op_q == 3'd4);
    assign q_fix = (op_q == 3'd3 && (a_neg_q ^ b_neg_q)) ? -quo_q : quo_q;
    assign r_fix = (op_q == 3'd5 && a_neg_q) ? -rem_q : rem_q;

    always_comb begin
        fix_res = is_q ? q_fix : r_fix;
        if (dz_q) begin
            fix_res = is_q ? '1 : a_q;
        end
    end

    // Divide-by-zero passes through FIX only to pick its fixed result.
    always_comb begin
        first_st = S_DONE;
        unique case (1'b1)
            op_mul:            first_st = S_MUL;
            op_div && b_zero:  first_st = S_FIX;
            op_div && !b_zero: first_st = S_DIV;
            default:           first_st = S_DONE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = first_st;
            S_MUL:  if (cnt_q == '0) state_d = S_DONE;
            S_DIV:  if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (!i_stall) state_d = accept ? first_st : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                pipe_q[i] <= '0;
            end
            op_q    <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            res_q   <= '0;
            rdz_q   <= 1'b0;
        end else begin
            pipe_q[0] <= mul_p;
            for (int i = 1; i < MUL_STAGES; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            if (state_q == S_MUL || state_q == S_DIV) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (state_q == S_DIV) begin
                rem_q <= rem_nx;
                quo_q <= {quo_q[XLEN-2:0], ge};
            end
            if (state_q == S_MUL && cnt_q == '0) begin
                res_q <= mul_res;
                rdz_q <= 1'b0;
            end
            if (state_q == S_FIX) begin
                res_q <= fix_res;
                rdz_q <= dz_q;
            end
            if (accept) begin
                op_q    <= i_op;
                tag_q   <= i_tag;
                cnt_q   <= op_mul ? MUL_CNT : DIV_CNT;
                a_q     <= i_a;
                dvs_q   <= b_mag;
                quo_q   <= a_mag;
                rem_q   <= '0;
                a_neg_q <= op_sgn && i_a[XLEN-1];
                b_neg_q <= op_sgn && i_b[XLEN-1];
                dz_q    <= op_div && b_zero;
                if (i_op == 3'd7) begin
                    res_q <= '0;
                    rdz_q <= 1'b0;
                end
            end
        end
    end

    assign o_valid       = (state_q == S_DONE);
    assign o_result      = o_valid ? res_q : '0;
    assign o_tag         = o_valid ? tag_q : '0;
    assign o_div_by_zero = o_valid && rdz_q;

endmodule

// File: tb/tb_tl45_muldiv.sv
// tb_tl45_muldiv: self-checking bench for tl45_muldiv (default parameters).
// Directed and random ops against a plain-arithmetic reference model.
module tb_tl45_muldiv;

    localparam int XLEN = 32;
    localparam int MS   = 3;
    localparam int TW   = 4;

    logic            clk = 1'b0;
    logic            i_reset, i_flush, i_valid, i_stall;
    logic            o_ready, o_valid, o_div_by_zero;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_a, i_b, o_result;
    logic [TW-1:0]   i_tag, o_tag;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tl45_muldiv #(.XLEN(XLEN), .MUL_STAGES(MS), .TAG_W(TW)) dut (
        .i_clk(clk),
        .i_reset(i_reset),
        .i_flush(i_flush),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_op(i_op),
        .i_a(i_a),
        .i_b(i_b),
        .i_tag(i_tag),
        .i_stall(i_stall),
        .o_valid(o_valid),
        .o_result(o_result),
        .o_tag(o_tag),
        .o_div_by_zero(o_div_by_zero)
    );

    function automatic logic [31:0] ref_res(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        logic [63:0] p;
        logic [63:0] q;
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd3: begin
                if (b == 0) return 32'hFFFF_FFFF;
                q = sa / sb; return q[31:0];
            end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd5: begin
                if (b == 0) return a;
                q = sa % sb; return q[31:0];
            end
            3'd6: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op,
                                   input logic [31:0] b);
        if (op <= 3'd2) return MS;
        if (op == 3'd7) return 0;
        if (b == 0) return 1;
        return XLEN + 1;
    endfunction

    // Presents one op, leaves the unit in DONE with the result visible.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag,
                          input logic [31:0] exp_r, input string nm);
        int cyc;
        int lat;
        logic edz;
        lat = ref_lat(op, b);
        edz = (op >= 3'd3) && (op <= 3'd6) && (b == 0);
        @(negedge clk);
        i_stall = 1'b0;
        i_valid = 1'b1;
        i_op = op; i_a = a; i_b = b; i_tag = tag;
        cyc = 0;
        while (!o_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready: got %b want 1", nm, o_ready);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_op = 3'($urandom); i_a = $urandom; i_b = $urandom;
        i_tag = 4'($urandom);
        cyc = 0;
        while (o_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_tests++;
        if (cyc != lat || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", nm, cyc, lat);
        end
        n_tests++;
        if (o_result !== exp_r || o_tag !== tag ||
            o_div_by_zero !== edz) begin
            n_fail++;
            $display("FAIL %s result: got %h/t%0d/z%b want %h/t%0d/z%b",
                     nm, o_result, o_tag, o_div_by_zero, exp_r, tag, edz);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        i_valid = 1'b0;
        i_stall = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_stall = 1'b0;
        i_op = '0; i_a = '0; i_b = '0; i_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        i_reset = 1'b0;
        n_tests++;
        if (o_valid !== 1'b0 || o_result !== '0 || o_tag !== '0 ||
            o_div_by_zero !== 1'b0 || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: got v%b r%h t%h z%b rdy%b want 0 0 0 0 1",
                     o_valid, o_result, o_tag, o_div_by_zero, o_ready);
        end
    endtask

    task automatic test_directed();
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 4'd5, 32'hFFFF_FFFA, "mul");
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 4'd6, 32'hFFFF_FFFF, "mulh");
        run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 4'd7, 32'h0000_0002, "mulhu");
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 4'd1, 32'hFFFF_FFFD, "div");
        run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 4'd2, 32'hFFFF_FFFF, "rem");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 4'd3, 32'h7FFF_FFFC, "udiv");
        run_op(3'd3, 32'h1234, 32'd0, 4'd4, 32'hFFFF_FFFF, "div0");
        run_op(3'd6, 32'h1234, 32'd0, 4'd8, 32'h0000_1234, "urem0");
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'd9, 32'h8000_0000,
               "divovf");
        run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 4'd10, 32'h0, "removf");
        run_op(3'd7, 32'h55, 32'h66, 4'd11, 32'h0, "resv");
        idle_cycle();
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [3:0]  tg;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = 32'($urandom_range(0, 100));
                2: a = 32'h8000_0000;
                default: a = -32'($urandom_range(1, 100));
            endcase
            case ($urandom_range(0, 4))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 20));
                2: b = -32'($urandom_range(1, 20));
                3: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            tg = 4'($urandom);
            run_op(op, a, b, tg, ref_res(op, a, b), "rand");
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();
    endtask

    task automatic test_stall();
        logic [31:0] hold;
        run_op(3'd0, 32'd1000, 32'd77, 4'd12, 32'd77000, "stallmul");
        @(negedge clk);
        i_stall = 1'b1;
        hold = 32'd77000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (o_valid !== 1'b1 || o_result !== hold || o_ready !== 1'b0 ||
                o_tag !== 4'd12) begin
                n_fail++;
                $display("FAIL stall_hold: got v%b %h rdy%b t%0d want 1 %h 0 12",
                         o_valid, o_result, o_ready, o_tag, hold);
            end
        end
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd13,
               32'hFFFF_FFFE, "b2b_mulhu");
        idle_cycle();
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        i_valid = 1'b1; i_op = 3'd3; i_a = 32'd1000; i_b = 32'd7;
        i_tag = 4'd3;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        n_tests++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_div: got rdy%b v%b want 1 0", o_ready, o_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (o_valid === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL flush_drop: got %0d valid cycles want 0", seen);
        end
        @(negedge clk);
        i_valid = 1'b1; i_flush = 1'b1; i_op = 3'd0;
        i_a = 32'd5; i_b = 32'd5;
        @(posedge clk);
        #1;
        i_valid = 1'b0; i_flush = 1'b0;
        n_tests++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_wins: got rdy%b v%b want 1 0", o_ready, o_valid);
        end
        repeat (MS + 2) @(posedge clk);
        #1;
        n_tests++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_wins_late: got v%b want 0", o_valid);
        end
        run_op(3'd6, 32'd100, 32'd7, 4'd14, 32'd2, "preflush");
        @(negedge clk);
        i_stall = 1'b0;
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        n_tests++;
        if (o_valid !== 1'b0 || o_result !== '0 || o_tag !== '0) begin
            n_fail++;
            $display("FAIL flush_done: got v%b %h t%0d want 0 0 0",
                     o_valid, o_result, o_tag);
        end
    endtask

    task automatic test_reset_done();
        run_op(3'd4, 32'hFFFF_FFFF, 32'd0, 4'd15, 32'hFFFF_FFFF, "prereset");
        @(negedge clk);
        i_stall = 1'b1;
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        i_stall = 1'b0;
        n_tests++;
        if (o_valid !== 1'b0 || o_result !== '0 || o_tag !== '0 ||
            o_div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got v%b %h t%0d z%b want 0 0 0 0",
                     o_valid, o_result, o_tag, o_div_by_zero);
        end
        run_op(3'd0, 32'd6, 32'd7, 4'd1, 32'd42, "postreset");
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_flush();
        test_reset_done();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
